switch_box_config_loader: RTL and testbench

//  Writer side of the switch-box configuration bus. Accepts a configuration frame
//  in CHUNK-bit pieces over a valid/ready stream and assembles it in a shadow

---
 rtl/switch_box_config_loader.sv | 106 ++++++++++
 tb/tb_switch_box_config_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_box_config_loader.sv
// Switch-box configuration loader: assembles CHUNK-bit pieces into a shadow frame and
// commits the whole frame to c in one cycle. Optional readback port under CFG_READBACK_EN.
module switch_box_config_loader #(
  parameter int unsigned WS     = 8,
  parameter int unsigned WD     = 8,
  parameter int unsigned CHUNK  = 8,
  localparam int unsigned CW     = (WS + WD / 2) * 6,
  localparam int unsigned NCHUNK = (CW + CHUNK - 1) / CHUNK,
  localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CHUNK-1:0] cfg_data,
`ifdef CFG_READBACK_EN
  input  logic [CNTW-1:0]  rb_idx,
  output logic [CHUNK-1:0] rb_data,
`endif
  output logic             cfg_ready,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic [CW-1:0]    c
);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  localparam logic [CW-1:0] ChunkMask = CW'({CHUNK{1'b1}});

  state_e          state;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   shadow;
  logic [CW-1:0]   wr_mask;
  logic [CW-1:0]   wr_data;
  logic            accept;

  // Shifting into a CW-wide vector drops chunk bits that fall past the frame end.
  always_comb begin
    wr_mask = ChunkMask << (32'(cnt) * CHUNK);
    wr_data = CW'(cfg_data) << (32'(cnt) * CHUNK);
    accept  = cfg_valid && cfg_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      shadow    <= '0;
      c         <= '0;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cfg_start) begin
            state     <= StLoad;
            cnt       <= '0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
          end
        end
        StLoad: begin
          // A restart takes priority over a chunk presented in the same cycle.
          if (cfg_start) begin
            cnt <= '0;
          end else if (accept) begin
            shadow <= (shadow & ~wr_mask) | wr_data;
            if (cnt == CNTW'(NCHUNK - 1)) begin
              state     <= StCommit;
              cnt       <= '0;
              cfg_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        StCommit: begin
          c        <= shadow;
          cfg_done <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= StIdle;
        end
        default: begin
          state     <= StIdle;
          cfg_ready <= 1'b0;
          cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CFG_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_data <= '0;
    end else if (32'(rb_idx) >= NCHUNK) begin
      rb_data <= '0;
    end else begin
      rb_data <= CHUNK'(c >> (32'(rb_idx) * CHUNK));
    end
  end
`endif

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Randomised self-checking bench for switch_box_config_loader (CHUNK=8 and CHUNK=5 instances).
module tb_switch_box_config_loader;

  localparam int CW = 72;
  localparam int N8 = 9;
  localparam int N5 = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, valid;
  logic [7:0]    data;
  logic          ready, busy, done;
  logic [CW-1:0] c;
  logic          start5, valid5;
  logic [4:0]    data5;
  logic          ready5, busy5, done5;
  logic [CW-1:0] c5;
`ifdef CFG_READBACK_EN
  logic [3:0]    rb_idx, rb5_idx;
  logic [7:0]    rb_data;
  logic [4:0]    rb5_data;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done5_cnt = 0;
  logic [CW-1:0] exp_c, exp_c5;
  logic [7:0] acc_q[$];
  logic [4:0] acc5_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (done5 === 1'b1) done5_cnt++;
  end

  switch_box_config_loader #(.WS(8), .WD(8), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(start), .cfg_valid(valid), .cfg_data(data),
`ifdef CFG_READBACK_EN
    .rb_idx(rb_idx), .rb_data(rb_data),
`endif
    .cfg_ready(ready), .cfg_busy(busy), .cfg_done(done), .c(c)
  );

  switch_box_config_loader #(.WS(8), .WD(8), .CHUNK(5)) dut5 (
    .clk(clk), .rst(rst), .cfg_start(start5), .cfg_valid(valid5), .cfg_data(data5),
`ifdef CFG_READBACK_EN
    .rb_idx(rb5_idx), .rb_data(rb5_data),
`endif
    .cfg_ready(ready5), .cfg_busy(busy5), .cfg_done(done5), .c(c5)
  );

  // Frame = the chunks accepted since the last start, packed LSB-first, cut at CW bits.
  function automatic logic [CW-1:0] model8();
    logic [CW-1:0] r = '0;
    for (int i = 0; i < CW; i++) r[i] = acc_q[i / 8][i % 8];
    return r;
  endfunction

  function automatic logic [CW-1:0] model5();
    logic [CW-1:0] r = '0;
    for (int i = 0; i < CW; i++) r[i] = acc5_q[i / 5][i % 5];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame, optionally sends restart_at chunks then restarts with a dropped chunk,
  // then sends the 9 chunks of f with random gaps. Returns in COMMIT.
  task automatic load8(input logic [CW-1:0] f, input int gap_pct, input int restart_at,
                       output int c_moves);
    logic [CW-1:0] c0;
    c0 = c;
    c_moves = 0;
    start = 1'b1;
    valid = 1'($urandom_range(0, 1));
    data = 8'($urandom);
    tick();
    start = 1'b0;
    acc_q.delete();
    if (restart_at > 0) begin
      for (int j = 0; j < restart_at; j++) begin
        valid = 1'b1;
        data = 8'($urandom);
        acc_q.push_back(data);
        tick();
        if (c !== c0) c_moves++;
      end
      start = 1'b1;
      valid = 1'b1;
      data = 8'hFF;
      tick();
      if (c !== c0) c_moves++;
      start = 1'b0;
      acc_q.delete();
    end
    for (int k = 0; k < N8; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        valid = 1'b0;
        data = 8'($urandom);
        tick();
        if (c !== c0) c_moves++;
      end
      valid = 1'b1;
      data = f[k*8 +: 8];
      acc_q.push_back(data);
      tick();
      if (c !== c0) c_moves++;
    end
    valid = 1'b0;
  endtask

  task automatic load5(input logic [74:0] f, input int gap_pct);
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    acc5_q.delete();
    for (int k = 0; k < N5; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        valid5 = 1'b0;
        tick();
      end
      valid5 = 1'b1;
      data5 = f[k*5 +: 5];
      acc5_q.push_back(data5);
      tick();
    end
    valid5 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (c !== '0) begin failures++; $display("FAIL reset_c got=%h exp=0", c); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (c5 !== '0) begin failures++; $display("FAIL reset_c5 got=%h exp=0", c5); end
    exp_c = '0;
    exp_c5 = '0;
  endtask

  task automatic test_full_frame();
    int m, base;
    logic [CW-1:0] f;
    f = 72'h090807060504030201;
    base = done_cnt;
    load8(f, 0, -1, m);
    checks++; if (m !== 0) begin failures++; $display("FAIL full_c_stable got=%0d exp=0", m); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_commit_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_commit_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_early_done got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done); end
    checks++; if (c !== f) begin failures++; $display("FAIL full_c got=%h exp=%h", c, f); end
    checks++; if (c !== model8()) begin failures++; $display("FAIL full_model got=%h exp=%h", c, model8()); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_width got=%b exp=0", done); end
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cnt - base); end
    exp_c = f;
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback();
    logic [7:0] e;
    for (int i = 0; i <= 12; i++) begin
      rb_idx = 4'(i);
      tick();
      e = (i < N8) ? exp_c[i*8 +: 8] : 8'h00;
      checks++;
      if (rb_data !== e) begin failures++; $display("FAIL readback idx=%0d got=%h exp=%h", i, rb_data, e); end
    end
  endtask

  task automatic test_readback5();
    logic [4:0] e;
    for (int i = 12; i <= 15; i++) begin
      rb5_idx = 4'(i);
      tick();
      e = '0;
      for (int b = 0; b < 5; b++) if (i < N5 && i * 5 + b < CW) e[b] = exp_c5[i*5 + b];
      checks++;
      if (rb5_data !== e) begin failures++; $display("FAIL readback5 idx=%0d got=%h exp=%h", i, rb5_data, e); end
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      valid = 1'b1;
      data = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (c !== '0) begin failures++; $display("FAIL midrst_c got=%h exp=0", c); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
`ifdef CFG_READBACK_EN
    checks++; if (rb_data !== '0) begin failures++; $display("FAIL midrst_rb got=%h exp=0", rb_data); end
`endif
    tick();
    rst = 1'b0;
    tick();
    exp_c = '0;
    exp_c5 = '0;
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL midrst_idle got=%b%b exp=00", busy, ready);
    end
  endtask

  task automatic test_idle_valid();
    int base;
    base = done_cnt;
    for (int j = 0; j < 10; j++) begin
      valid = 1'b1;
      data = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL idle_valid_state got=%b%b exp=00", busy, ready);
    end
    checks++; if (c !== exp_c || done_cnt !== base) begin
      failures++; $display("FAIL idle_valid_c got=%h exp=%h", c, exp_c);
    end
  endtask

  task automatic test_gaps();
    int m, base;
    logic [CW-1:0] r, f;
    f = 72'h090807060504030201;
    r = {8'($urandom), 32'($urandom), 32'($urandom)};
    base = done_cnt;
    load8(r, 50, -1, m);
    tick();
    checks++; if (c !== model8()) begin failures++; $display("FAIL gaps_rand got=%h exp=%h", c, model8()); end
    load8(f, 50, -1, m);
    checks++; if (m !== 0) begin failures++; $display("FAIL gaps_c_stable got=%0d exp=0", m); end
    tick();
    checks++; if (c !== f) begin failures++; $display("FAIL gaps_c got=%h exp=%h", c, f); end
    tick();
    checks++; if (done_cnt - base !== 2) begin failures++; $display("FAIL gaps_done_count got=%0d exp=2", done_cnt - base); end
    exp_c = f;
  endtask

  task automatic test_restart();
    int m, base;
    logic [CW-1:0] f;
    f = {9{8'hA5}};
    base = done_cnt;
    load8(f, 30, 4, m);
    checks++; if (m !== 0) begin failures++; $display("FAIL restart_c_stable got=%0d exp=0", m); end
    checks++; if (done_cnt !== base) begin failures++; $display("FAIL restart_early_commit got=%0d exp=%0d", done_cnt, base); end
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
      failures++; $display("FAIL restart_commit_state got=%b%b exp=10", busy, ready);
    end
    tick();
    checks++; if (c !== f) begin failures++; $display("FAIL restart_c got=%h exp=%h", c, f); end
    exp_c = f;
  endtask

  task automatic test_commit_start();
    int m;
    logic [CW-1:0] r;
    r = {8'($urandom), 32'($urandom), 32'($urandom)};
    load8(r, 0, -1, m);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || c !== r) begin
      failures++; $display("FAIL commit_start_done got=%b/%h exp=1/%h", done, c, r);
    end
    tick();
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL commit_start_idle got=%b%b exp=00", busy, ready);
    end
    exp_c = r;
  endtask

  task automatic test_back_to_back();
    int m, ra;
    logic [CW-1:0] r;
    for (int it = 0; it < 12; it++) begin
      r = {8'($urandom), 32'($urandom), 32'($urandom)};
      ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      load8(r, int'($urandom_range(0, 60)), ra, m);
      checks++; if (m !== 0) begin failures++; $display("FAIL b2b_c_stable it=%0d got=%0d exp=0", it, m); end
      tick();
      checks++; if (c !== model8() || done !== 1'b1) begin
        failures++; $display("FAIL b2b_c it=%0d got=%h/%b exp=%h/1", it, c, done, model8());
      end
    end
    exp_c = model8();
  endtask

  task automatic test_chunk5();
    int base;
    logic [74:0] f;
    base = done5_cnt;
    f = {15{5'h1F}};
    load5(f, 0);
    checks++; if (ready5 !== 1'b0 || busy5 !== 1'b1) begin
      failures++; $display("FAIL c5_commit_state got=%b%b exp=01", ready5, busy5);
    end
    tick();
    checks++; if (c5 !== {CW{1'b1}}) begin failures++; $display("FAIL c5_ones got=%h exp=all ones", c5); end
    f = {11'($urandom), 32'($urandom), 32'($urandom)};
    load5(f, 40);
    tick();
    checks++; if (c5 !== model5()) begin failures++; $display("FAIL c5_rand got=%h exp=%h", c5, model5()); end
    tick();
    checks++; if (done5_cnt - base !== 2 || busy5 !== 1'b0) begin
      failures++; $display("FAIL c5_done_count got=%0d exp=2", done5_cnt - base);
    end
    exp_c5 = model5();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; valid = 1'b0; data = '0;
    start5 = 1'b0; valid5 = 1'b0; data5 = '0;
`ifdef CFG_READBACK_EN
    rb_idx = '0; rb5_idx = '0;
`endif
    test_reset();
    test_full_frame();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    test_reset_mid_load();
    test_idle_valid();
    test_gaps();
    test_restart();
    test_commit_start();
    test_back_to_back();
    test_chunk5();
`ifdef CFG_READBACK_EN
    test_readback();
    test_readback5();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
